// File: rtl/i2c_master_fsm.sv
// Byte-level I2C master sequencer driven by the stretch generator's data_clk.
// Produces start/stop, command, write/read bytes and ACK handling on an open-drain SDA.
module i2c_master_fsm #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_clk,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [7:0]        data_wr,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              scl_not_ena,
  output logic              busy,
  output logic              wr_req,
  output logic [7:0]        data_rd,
  output logic              rd_valid,
  output logic              ack_error
);

  localparam int CMD_W = ADDR_W + 1;
  localparam int CNT_W = (CMD_W > 8) ? $clog2(CMD_W) : 3;

  typedef enum logic [3:0] {
    S_READY, S_START, S_COMMAND, S_SLV_ACK1, S_WR,
    S_SLV_ACK2, S_RD, S_MSTR_ACK, S_STOP
  } state_t;

  state_t             r_state;
  logic               r_dclk_prev;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_last;
  logic [CMD_W-1:0]   r_cmd;
  logic [7:0]         r_tx;
  logic [7:0]         r_rx;
  logic               r_sda_oe;
  logic               r_scl_not_ena;
  logic               r_busy;
  logic               r_wr_req;
  logic [7:0]         r_data_rd;
  logic               r_rd_valid;
  logic               r_ack_error;

  logic               w_rise;
  logic               w_fall;
  logic [CMD_W-1:0]   w_cmd_in;
  logic               w_same;

  assign w_rise   = data_clk & ~r_dclk_prev;
  assign w_fall   = ~data_clk & r_dclk_prev;
  assign w_cmd_in = {addr, rw};
  assign w_same   = (w_cmd_in == r_cmd);

  // r_last marks that bit 0 has been handled, so the counter never has to go below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_READY;
      r_dclk_prev   <= 1'b0;
      r_bit_cnt     <= CNT_W'(7);
      r_last        <= 1'b0;
      r_cmd         <= '0;
      r_tx          <= '0;
      r_rx          <= '0;
      r_sda_oe      <= 1'b0;
      r_scl_not_ena <= 1'b1;
      r_busy        <= 1'b0;
      r_wr_req      <= 1'b0;
      r_data_rd     <= '0;
      r_rd_valid    <= 1'b0;
      r_ack_error   <= 1'b0;
    end else begin
      r_dclk_prev <= data_clk;
      r_wr_req    <= 1'b0;
      r_rd_valid  <= 1'b0;
      case (r_state)
        S_READY: begin
          if (w_rise && ena) begin
            r_cmd         <= w_cmd_in;
            r_tx          <= data_wr;
            r_wr_req      <= 1'b1;
            r_busy        <= 1'b1;
            r_scl_not_ena <= 1'b0;
            r_ack_error   <= 1'b0;
            r_state       <= S_START;
          end
        end
        S_START: begin
          if (w_fall) begin
            r_sda_oe <= 1'b1;
          end else if (w_rise) begin
            r_sda_oe  <= ~r_cmd[CMD_W-1];
            r_bit_cnt <= CNT_W'(CMD_W-2);
            r_last    <= 1'b0;
            r_state   <= S_COMMAND;
          end
        end
        S_COMMAND: begin
          if (w_rise) begin
            if (r_last) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= CNT_W'(7);
              r_last    <= 1'b0;
              r_state   <= S_SLV_ACK1;
            end else begin
              r_sda_oe <= ~r_cmd[r_bit_cnt];
              if (r_bit_cnt == '0) r_last <= 1'b1;
              else                 r_bit_cnt <= r_bit_cnt - 1'b1;
            end
          end
        end
        S_SLV_ACK1: begin
          if (w_fall) begin
            if (sda_in) r_ack_error <= 1'b1;
          end else if (w_rise) begin
            r_last <= 1'b0;
            if (!r_cmd[0]) begin
              r_sda_oe  <= ~r_tx[7];
              r_bit_cnt <= CNT_W'(6);
              r_state   <= S_WR;
            end else begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= CNT_W'(7);
              r_state   <= S_RD;
            end
          end
        end
        S_WR: begin
          if (w_rise) begin
            if (r_last) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= CNT_W'(7);
              r_last    <= 1'b0;
              r_state   <= S_SLV_ACK2;
            end else begin
              r_sda_oe <= ~r_tx[r_bit_cnt];
              if (r_bit_cnt == '0) r_last <= 1'b1;
              else                 r_bit_cnt <= r_bit_cnt - 1'b1;
            end
          end
        end
        S_SLV_ACK2: begin
          if (w_fall) begin
            if (sda_in) r_ack_error <= 1'b1;
          end else if (w_rise) begin
            if (ena && w_same) begin
              r_tx      <= data_wr;
              r_wr_req  <= 1'b1;
              r_sda_oe  <= ~data_wr[7];
              r_bit_cnt <= CNT_W'(6);
              r_last    <= 1'b0;
              r_state   <= S_WR;
            end else if (ena) begin
              r_cmd    <= w_cmd_in;
              r_sda_oe <= 1'b0;
              r_state  <= S_START;
            end else begin
              r_sda_oe <= 1'b1;
              r_state  <= S_STOP;
            end
          end
        end
        S_RD: begin
          if (w_fall && !r_last) begin
            r_rx <= {r_rx[6:0], sda_in};
            if (r_bit_cnt == '0) r_last <= 1'b1;
            else                 r_bit_cnt <= r_bit_cnt - 1'b1;
          end else if (w_rise && r_last) begin
            r_data_rd  <= r_rx;
            r_rd_valid <= 1'b1;
            r_sda_oe   <= ena && w_same;
            r_last     <= 1'b0;
            r_state    <= S_MSTR_ACK;
          end
        end
        S_MSTR_ACK: begin
          if (w_rise) begin
            if (ena && w_same) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= CNT_W'(7);
              r_last    <= 1'b0;
              r_state   <= S_RD;
            end else if (ena) begin
              r_cmd    <= w_cmd_in;
              r_sda_oe <= 1'b0;
              r_state  <= S_START;
            end else begin
              r_sda_oe <= 1'b1;
              r_state  <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_sda_oe <= 1'b0;
          end else if (w_rise) begin
            r_busy        <= 1'b0;
            r_scl_not_ena <= 1'b1;
            r_state       <= S_READY;
          end
        end
        default: r_state <= S_READY;
      endcase
    end
  end

  assign sda_oe      = r_sda_oe;
  assign scl_not_ena = r_scl_not_ena;
  assign busy        = r_busy;
  assign wr_req      = r_wr_req;
  assign data_rd     = r_data_rd;
  assign rd_valid    = r_rd_valid;
  assign ack_error   = r_ack_error;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Bench for i2c_master_fsm: a protocol-level frame generator builds the expected
// SDA/handshake waveform per data_clk event; a compare process checks every clk.
module tb_i2c_master_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_clk = 1'b0;
  logic       ena = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] data_wr = '0;
  logic       sda_in = 1'b0;
  logic       sda_oe, scl_not_ena, busy, wr_req, rd_valid, ack_error;
  logic [7:0] data_rd;

  i2c_master_fsm #(.ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .data_clk(data_clk), .ena(ena), .addr(addr),
    .rw(rw), .data_wr(data_wr), .sda_in(sda_in), .sda_oe(sda_oe),
    .scl_not_ena(scl_not_ena), .busy(busy), .wr_req(wr_req),
    .data_rd(data_rd), .rd_valid(rd_valid), .ack_error(ack_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       rise;
    bit       ena;
    bit [6:0] addr;
    bit       rw;
    bit [7:0] dwr;
    bit       sda;
    bit       oe;
    bit       busy;
    bit       wrq;
    bit       rv;
    bit [7:0] drd;
    bit       err;
  } ev_t;

  ev_t      evq[$];
  bit       m_oe, m_busy, m_err;
  bit [7:0] m_drd, m_tx;
  bit       exp_oe, exp_busy, exp_wrq, exp_rv, exp_err;
  bit [7:0] exp_drd;
  bit       chk_en;
  int       total, bad, cnt_wrq, cnt_rv;
  bit [63:0] oe_log;

  // transaction script: up to 3 segments of up to 3 bytes
  bit [6:0] sc_addr[3];
  bit       sc_rw[3];
  int       sc_nb[3];
  bit [7:0] sc_dat[3][3];
  bit       sc_nack[3];
  bit       sc_bnack[3][3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      if (bad <= 30) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sda_oe", 64'(sda_oe), 64'(exp_oe));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("scl_not_ena", 64'(scl_not_ena), 64'(!exp_busy));
      chk("wr_req", 64'(wr_req), 64'(exp_wrq));
      chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
      chk("data_rd", 64'(data_rd), 64'(exp_drd));
      chk("ack_error", 64'(ack_error), 64'(exp_err));
      if (wr_req) cnt_wrq++;
      if (rd_valid) cnt_rv++;
    end
  end

  task automatic push(input bit r, input bit e, input bit [6:0] a, input bit w,
                      input bit [7:0] d, input bit s, input bit wq, input bit rv);
    ev_t x;
    x.rise = r; x.ena = e; x.addr = a; x.rw = w; x.dwr = d; x.sda = s;
    x.oe = m_oe; x.busy = m_busy; x.wrq = wq; x.rv = rv; x.drd = m_drd; x.err = m_err;
    evq.push_back(x);
  endtask

  task automatic rise_s(input bit e, input bit [6:0] a, input bit w, input bit wq, input bit rv);
    push(1'b1, e, a, w, 8'($urandom), 1'($urandom), wq, rv);
  endtask

  task automatic rise_x();
    push(1'b1, 1'($urandom), 7'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic fall_s(input bit s);
    push(1'b0, 1'($urandom), 7'($urandom), 1'($urandom), 8'($urandom), s, 1'b0, 1'b0);
  endtask

  task automatic gen_idle(input int n);
    for (int i = 0; i < n; i++) begin
      rise_s(1'b0, 7'($urandom), 1'($urandom), 1'b0, 1'b0);
      fall_s(1'($urandom));
    end
  endtask

  // start (or repeated start) condition, 8 command bits, slave ACK slot
  task automatic gen_addr(input bit [7:0] cmd, input bit nack);
    m_oe = 1'b1;
    fall_s(1'($urandom));
    for (int i = 7; i >= 0; i--) begin
      m_oe = !cmd[i];
      rise_x();
      fall_s(1'($urandom));
    end
    m_oe = 1'b0;
    rise_x();
    m_err = m_err | nack;
    fall_s(nack);
  endtask

  // rest of a written byte once bit 7 is on the line, then the slave ACK slot
  task automatic gen_wbody(input bit [7:0] tx, input bit nack);
    fall_s(1'($urandom));
    for (int i = 6; i >= 0; i--) begin
      m_oe = !tx[i];
      rise_x();
      fall_s(1'($urandom));
    end
    m_oe = 1'b0;
    rise_x();
    m_err = m_err | nack;
    fall_s(nack);
  endtask

  task automatic gen_rbody(input bit [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      fall_s(b[i]);
      if (i > 0) rise_x();
    end
  endtask

  task automatic gen_txn(input int nseg);
    bit [7:0] cmd;
    bit [6:0] na;
    bit       nrw;
    bit       last;
    m_busy = 1'b1;
    m_err  = 1'b0;
    m_tx   = sc_rw[0] ? 8'($urandom) : sc_dat[0][0];
    push(1'b1, 1'b1, sc_addr[0], sc_rw[0], m_tx, 1'($urandom), 1'b1, 1'b0);
    for (int s = 0; s < nseg; s++) begin
      cmd  = {sc_addr[s], sc_rw[s]};
      last = (s == nseg - 1);
      na   = last ? 7'($urandom) : sc_addr[s+1];
      nrw  = last ? 1'($urandom) : sc_rw[s+1];
      gen_addr(cmd, sc_nack[s]);
      if (!sc_rw[s]) begin
        m_oe = !m_tx[7];
        rise_x();
        gen_wbody(m_tx, sc_bnack[s][0]);
        for (int b = 1; b < sc_nb[s]; b++) begin
          m_tx = sc_dat[s][b];
          m_oe = !m_tx[7];
          push(1'b1, 1'b1, sc_addr[s], 1'b0, m_tx, 1'($urandom), 1'b1, 1'b0);
          gen_wbody(m_tx, sc_bnack[s][b]);
        end
        m_oe = last;
        rise_s(!last, na, nrw, 1'b0, 1'b0);
      end else begin
        m_oe = 1'b0;
        rise_x();
        for (int b = 0; b < sc_nb[s]; b++) begin
          gen_rbody(sc_dat[s][b]);
          m_drd = sc_dat[s][b];
          if (b < sc_nb[s] - 1) begin
            m_oe = 1'b1;
            rise_s(1'b1, sc_addr[s], 1'b1, 1'b0, 1'b1);
            fall_s(1'($urandom));
            m_oe = 1'b0;
            rise_s(1'b1, sc_addr[s], 1'b1, 1'b0, 1'b0);
          end else begin
            m_oe = 1'b0;
            rise_s(!last, na, nrw, 1'b0, 1'b1);
            fall_s(1'($urandom));
            m_oe = last;
            rise_s(!last, na, nrw, 1'b0, 1'b0);
          end
        end
      end
    end
    m_oe = 1'b0;
    fall_s(1'($urandom));
    m_busy = 1'b0;
    rise_x();
    fall_s(1'($urandom));
  endtask

  // plays queued events; entered and left at posedge+1
  task automatic run_q(input int lim);
    int n;
    n = 0;
    while (evq.size() > 0 && (lim < 0 || n < lim)) begin
      ev_t e;
      e = evq.pop_front();
      n++;
      data_clk = e.rise; ena = e.ena; addr = e.addr; rw = e.rw; data_wr = e.dwr; sda_in = e.sda;
      @(posedge clk); #1;
      exp_oe = e.oe; exp_busy = e.busy; exp_wrq = e.wrq; exp_rv = e.rv;
      exp_drd = e.drd; exp_err = e.err;
      oe_log = {oe_log[62:0], sda_oe};
      ena = 1'($urandom); addr = 7'($urandom); rw = 1'($urandom);
      data_wr = 8'($urandom); sda_in = 1'($urandom);
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #1;
        exp_wrq = 1'b0; exp_rv = 1'b0;
      end
    end
  endtask

  task automatic seg(input int s, input bit [6:0] a, input bit w, input int nb,
                     input bit [7:0] d0, input bit [7:0] d1, input bit nack);
    sc_addr[s] = a; sc_rw[s] = w; sc_nb[s] = nb;
    sc_dat[s][0] = d0; sc_dat[s][1] = d1; sc_dat[s][2] = 8'($urandom);
    sc_nack[s] = nack;
    for (int b = 0; b < 3; b++) sc_bnack[s][b] = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 1'b0; cnt_wrq = 0; cnt_rv = 0; oe_log = '0;
    m_oe = 0; m_busy = 0; m_err = 0; m_drd = '0; m_tx = '0;
    exp_oe = 0; exp_busy = 0; exp_wrq = 0; exp_rv = 0; exp_err = 0; exp_drd = '0;
    repeat (2) @(negedge clk);
    chk("rst_sda_oe", 64'(sda_oe), 64'(0));
    chk("rst_scl_not_ena", 64'(scl_not_ena), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_wr_req", 64'(wr_req), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_data_rd", 64'(data_rd), 64'(0));
    chk("rst_ack_error", 64'(ack_error), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // write 0x50 / 0xA5, stop
    seg(0, 7'h50, 1'b0, 1, 8'hA5, 8'h00, 1'b0);
    gen_idle(2); run_q(-1);
    oe_log = '0; cnt_wrq = 0;
    gen_txn(1); run_q(-1);
    chk("wr_sda_seq", 64'(oe_log[41:0]),
        64'(42'b01_0011001111111111_00_0011001111001100_00_1000));
    chk("wr_req_count", 64'(cnt_wrq), 64'(1));
    chk("wr_ack_error", 64'(ack_error), 64'(0));

    // read 0x3C returns 0x96, master NACK, stop
    seg(0, 7'h3C, 1'b1, 1, 8'h96, 8'h00, 1'b0);
    cnt_rv = 0;
    gen_idle(1); gen_txn(1); run_q(-1);
    chk("rd_data", 64'(data_rd), 64'(8'h96));
    chk("rd_valid_count", 64'(cnt_rv), 64'(1));

    // two bytes, same command
    seg(0, 7'h50, 1'b0, 2, 8'h11, 8'h22, 1'b0);
    cnt_wrq = 0;
    gen_idle(1); gen_txn(1); run_q(-1);
    chk("wr2_req_count", 64'(cnt_wrq), 64'(2));

    // write then repeated start as read of the same address (command 0xA1)
    seg(0, 7'h50, 1'b0, 1, 8'h3C, 8'h00, 1'b0);
    seg(1, 7'h50, 1'b1, 1, 8'h5A, 8'h00, 1'b0);
    cnt_rv = 0;
    gen_idle(1); gen_txn(2); run_q(-1);
    chk("rs_rd_data", 64'(data_rd), 64'(8'h5A));
    chk("rs_rd_valid_count", 64'(cnt_rv), 64'(1));

    // address NACK: sticky until the next transaction starts
    seg(0, 7'h22, 1'b0, 1, 8'h0F, 8'h00, 1'b1);
    gen_idle(1); gen_txn(1); gen_idle(2); run_q(-1);
    chk("nack_sticky", 64'(ack_error), 64'(1));
    seg(0, 7'h22, 1'b0, 1, 8'hF0, 8'h00, 1'b0);
    gen_txn(1); run_q(-1);
    chk("nack_cleared", 64'(ack_error), 64'(0));

    // reset while tx bit 3 of 0xA5 (a 0, so SDA pulled) is on the line
    seg(0, 7'h50, 1'b0, 1, 8'hA5, 8'h00, 1'b0);
    gen_idle(1); run_q(-1);
    gen_txn(1); run_q(29);
    chk("pre_rst_sda_oe", 64'(sda_oe), 64'(1));
    chk("pre_rst_busy", 64'(busy), 64'(1));
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sda_oe", 64'(sda_oe), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_scl_not_ena", 64'(scl_not_ena), 64'(1));
    evq.delete();
    m_oe = 0; m_busy = 0; m_err = 0; m_drd = '0;
    exp_oe = 0; exp_busy = 0; exp_wrq = 0; exp_rv = 0; exp_err = 0; exp_drd = '0;
    data_clk = 1'b0; ena = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    seg(0, 7'h41, 1'b0, 2, 8'hC3, 8'h7E, 1'b0);
    cnt_wrq = 0;
    gen_idle(1); gen_txn(1); run_q(-1);
    chk("post_rst_wr_req_count", 64'(cnt_wrq), 64'(2));

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      int nseg;
      nseg = $urandom_range(1, 3);
      for (int s = 0; s < nseg; s++) begin
        sc_addr[s] = 7'($urandom);
        sc_rw[s]   = 1'($urandom);
        if (s > 0 && {sc_addr[s], sc_rw[s]} == {sc_addr[s-1], sc_rw[s-1]}) sc_rw[s] = !sc_rw[s];
        sc_nb[s]   = $urandom_range(1, 3);
        sc_nack[s] = ($urandom_range(0, 5) == 0);
        for (int b = 0; b < 3; b++) begin
          sc_dat[s][b]   = 8'($urandom);
          sc_bnack[s][b] = ($urandom_range(0, 5) == 0);
        end
      end
      gen_idle($urandom_range(0, 2));
      gen_txn(nseg);
      run_q(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
